// File: rtl/tick_consumer_timer.sv
// rtl/tick_consumer_timer.sv - divided-clock strobes, coin debounce and start/cancel countdown
module tick_consumer_timer #(
    parameter int TW     = 8,
    parameter int DEB_MS = 20,
    parameter int DEB_W  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_1ms,
    input  logic          clk_1s,
    input  logic          coin_raw,
    input  logic          start,
    input  logic          cancel,
    input  logic [TW-1:0] load_val,
    output logic          tick_ms,
    output logic          tick_slow,
    output logic          coin_pulse,
    output logic          busy,
    output logic [TW-1:0] remaining,
    output logic          expired
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [2:0]       ms_sr;
    logic [2:0]       slow_sr;
    logic [1:0]       coin_sr;
    logic [1:0]       prime_cnt;
    logic             primed;
    logic             deb_lvl;
    logic             deb_prev;
    logic [DEB_W-1:0] deb_cnt;
    state_t           state;
    state_t           state_nx;
    logic [TW-1:0]    rem_nx;
    logic             busy_nx;

    // Strobes are held off until the sync chain has been refilled after reset,
    // so a divided clock that is already high does not look like a fresh edge.
    assign primed = (prime_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_sr     <= '0;
            slow_sr   <= '0;
            coin_sr   <= '0;
            prime_cnt <= '0;
            tick_ms   <= 1'b0;
            tick_slow <= 1'b0;
        end else begin
            ms_sr     <= {ms_sr[1:0], clk_1ms};
            slow_sr   <= {slow_sr[1:0], clk_1s};
            coin_sr   <= {coin_sr[0], coin_raw};
            if (!primed)
                prime_cnt <= prime_cnt + 2'd1;
            tick_ms   <= primed & ms_sr[1] & ~ms_sr[2];
            tick_slow <= primed & slow_sr[1] & ~slow_sr[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl    <= 1'b0;
            deb_prev   <= 1'b0;
            deb_cnt    <= '0;
            coin_pulse <= 1'b0;
        end else begin
            deb_prev   <= deb_lvl;
            coin_pulse <= deb_lvl & ~deb_prev;
            if (tick_ms) begin
                if (coin_sr[1] == deb_lvl) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_W'(DEB_MS - 1)) begin
                    deb_lvl <= coin_sr[1];
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end
    end

    // cancel beats start beats the slow tick; DONE lasts exactly one cycle.
    always_comb begin
        state_nx = state;
        rem_nx   = remaining;
        busy_nx  = busy;
        if (cancel) begin
            state_nx = IDLE;
            rem_nx   = '0;
            busy_nx  = 1'b0;
        end else if (start) begin
            if (load_val == '0) begin
                state_nx = DONE;
                rem_nx   = '0;
                busy_nx  = 1'b0;
            end else begin
                state_nx = RUN;
                rem_nx   = load_val;
                busy_nx  = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (tick_slow) begin
                        if (remaining <= TW'(1)) begin
                            state_nx = DONE;
                            rem_nx   = '0;
                            busy_nx  = 1'b0;
                        end else begin
                            rem_nx = remaining - 1'b1;
                        end
                    end
                end
                DONE:    state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            busy      <= busy_nx;
            expired   <= (state_nx == DONE);
        end
    end

endmodule
